// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register map, CTRL bit index and FSM states
// shared by the interrupt controller files.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_REG_ACTIVE  = 2'd2;
  localparam logic [1:0] IRQ_REG_CTRL    = 2'd3;

  localparam int IRQ_CTRL_GIE = 0;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pick.sv
// irq_pick: combinational picker, mask + start -> {valid, id}.
// IRQ_RR_EN: rotate search from start; else index 0 wins.
module irq_pick
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = 3
) (
  input  logic [NSRC-1:0] mask,
  input  logic [IDW-1:0]  start,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  int k;

  // Scan from the far end so the last hit,
  // the closest to the search origin, wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    k     = 0;
    for (int i = NSRC - 1; i >= 0; i--) begin
`ifdef IRQ_RR_EN
      k = (int'(start) + i) % NSRC;
`else
      k = i;
`endif
      if (mask[k]) begin
        valid = 1'b1;
        id    = IDW'(k);
      end
    end
  end

`ifndef IRQ_RR_EN
  logic unused_start;
  assign unused_start = ^start;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-detected pending/enable regs, arbiter and
// req/take/ret handshake to the core. Macro: IRQ_RR_EN.
// Ports: i_clk,i_rst | i_src | MMIO i_sel,i_we,i_addr,i_wdata,
// o_rdata | o_irq_req,o_irq_id,i_irq_take,i_irq_ret,o_in_irq
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int DW   = 16,
  parameter int IDW  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_sel,
  input  logic            i_we,
  input  logic [1:0]      i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata,
  output logic            o_irq_req,
  output logic [IDW-1:0]  o_irq_id,
  input  logic            i_irq_take,
  input  logic            i_irq_ret,
  output logic            o_in_irq
);

  irq_state_e      state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic            gie;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] take_clr;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  pick_id;
  logic            pick_vld;
  logic            wr;
  logic            rd;
  logic            take;
  logic [DW-1:0]   rdata_n;

  assign wr   = i_sel & i_we;
  assign rd   = i_sel & ~i_we;
  assign rise = i_src & ~src_q;
  assign elig = pending & enable & {NSRC{gie}};
  assign take = (state == IRQ_REQ) & i_irq_take;

  assign w1c = (wr && i_addr == IRQ_REG_PENDING)
             ? i_wdata[NSRC-1:0] : '0;

  assign take_clr = take
                  ? (NSRC'(1) << id_q) : '0;

  assign o_irq_id = id_q;

  irq_pick #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_pick (
    .mask  (elig),
    .start (ptr),
    .valid (pick_vld),
    .id    (pick_id)
  );

`ifdef IRQ_RR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (id_q == IDW'(NSRC - 1))
           ? '0 : id_q + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // src_q follows the pins even in reset, so a level
  // already high at release is not seen as an edge.
  // Rise beats W1C; a take clear beats both.
  always_ff @(posedge i_clk) begin
    src_q <= i_src;
    if (i_rst) begin
      pending <= '0;
      enable  <= '0;
      gie     <= 1'b0;
    end else begin
      pending <= ((pending & ~w1c) | rise) & ~take_clr;
      if (wr && i_addr == IRQ_REG_ENABLE)
        enable <= i_wdata[NSRC-1:0];
      if (wr && i_addr == IRQ_REG_CTRL)
        gie <= i_wdata[IRQ_CTRL_GIE];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IRQ_IDLE;
      o_irq_req <= 1'b0;
      o_in_irq  <= 1'b0;
      id_q      <= '0;
    end else begin
      unique case (state)
        IRQ_IDLE: begin
          if (pick_vld) begin
            state     <= IRQ_REQ;
            id_q      <= pick_id;
            o_irq_req <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (i_irq_take) begin
            state     <= IRQ_SVC;
            o_irq_req <= 1'b0;
            o_in_irq  <= 1'b1;
          end else if (elig == '0) begin
            state     <= IRQ_IDLE;
            o_irq_req <= 1'b0;
          end
        end
        IRQ_SVC: begin
          if (i_irq_ret) begin
            state    <= IRQ_IDLE;
            o_in_irq <= 1'b0;
          end
        end
        default: begin
          state     <= IRQ_IDLE;
          o_irq_req <= 1'b0;
          o_in_irq  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_n = '0;
    unique case (i_addr)
      IRQ_REG_PENDING: rdata_n = DW'(pending);
      IRQ_REG_ENABLE:  rdata_n = DW'(enable);
      IRQ_REG_ACTIVE:  rdata_n = DW'({o_in_irq, id_q});
      IRQ_REG_CTRL:    rdata_n[IRQ_CTRL_GIE] = gie;
      default:         rdata_n = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (rd) begin
      o_rdata <= rdata_n;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^i_wdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic
// checked against a per-cycle behavioural model.
module tb_irq_ctrl;

  localparam int NSRC = 4;
  localparam int DW   = 16;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            sel;
  logic            we;
  logic [1:0]      addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            req;
  logic [IDW-1:0]  id;
  logic            take;
  logic            ret;
  logic            in_irq;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(
    .NSRC (NSRC),
    .DW   (DW),
    .IDW  (IDW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_src      (src),
    .i_sel      (sel),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_irq_req  (req),
    .o_irq_id   (id),
    .i_irq_take (take),
    .i_irq_ret  (ret),
    .o_in_irq   (in_irq)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 requesting, 2 servicing
  bit          mp[NSRC];
  bit          me[NSRC];
  bit          mprev[NSRC];
  bit          mg;
  int          mmode;
  int          mid;
  int          mptr;
  bit          mreq;
  bit          min;
  logic [DW-1:0] mrd;

  // advance model and DUT by one clock; compares
  // happen on the following falling edge
  task automatic cyc();
    int pick;
    int clr;
    bit any;
    logic [DW-1:0] rv;
    if (rst) begin
      for (int k = 0; k < NSRC; k++) begin
        mp[k] = 0;
        me[k] = 0;
        mprev[k] = src[k];
      end
      mg = 0; mmode = 0; mid = 0; mptr = 0;
      mreq = 0; min = 0; mrd = '0;
    end else begin
      any = 0; pick = 0; clr = -1;
      for (int j = NSRC - 1; j >= 0; j--) begin
        int k;
        k = (mptr + j) % NSRC;
        if (mp[k] && me[k] && mg) begin
          any = 1;
          pick = k;
        end
      end
      if (sel && !we) begin
        rv = '0;
        for (int k = 0; k < NSRC; k++) begin
          if (addr == 0 && mp[k]) rv += DW'(1 << k);
          if (addr == 1 && me[k]) rv += DW'(1 << k);
        end
        if (addr == 2) rv = DW'(min * (1 << IDW) + mid);
        if (addr == 3) rv = DW'(mg);
        mrd = rv;
      end
      if (mmode == 0 && any) begin
        mmode = 1; mid = pick; mreq = 1;
      end else if (mmode == 1 && take) begin
        mmode = 2; mreq = 0; min = 1; clr = mid;
`ifdef IRQ_RR_EN
        mptr = (mid + 1) % NSRC;
`endif
      end else if (mmode == 1 && !any) begin
        mmode = 0; mreq = 0;
      end else if (mmode == 2 && ret) begin
        mmode = 0; min = 0;
      end
      for (int k = 0; k < NSRC; k++) begin
        bit rose;
        bit wc;
        rose = src[k] && !mprev[k];
        wc = sel && we && addr == 0 && wdata[k];
        mp[k] = (mp[k] && !wc) || rose;
        if (k == clr) mp[k] = 0;
        if (sel && we && addr == 1) me[k] = wdata[k];
        mprev[k] = src[k];
      end
      if (sel && we && addr == 3) mg = wdata[0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [DW-1:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    cyc();
    sel = 0; we = 0;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [DW-1:0] d);
    sel = 1; we = 0; addr = a;
    cyc();
    sel = 0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    rst = 1; src = 4'hF;
    repeat (3) cyc();
    total++;
    if (req !== 1'b0 || in_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got req=%b in=%b exp 0 0",
               req, in_irq);
    end
    total++;
    if (id !== '0 || rdata !== '0) begin
      bad++;
      $display("FAIL reset_out got id=%0d rd=%0h exp 0 0",
               id, rdata);
    end
    rst = 0;
    repeat (3) cyc();
    rd(2'd0, d);
    total++;
    if (d !== '0 || req !== 1'b0) begin
      bad++;
      $display("FAIL reset_held got pend=%0h req=%b exp 0 0",
               d, req);
    end
    src = 4'h0;
    cyc();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    wr(2'd1, 16'h3);
    wr(2'd3, 16'h1);
    src = 4'b0010;
    cyc();
    src = 4'h0;
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL basic_early got req=%b exp 0", req);
    end
    cyc();
    total++;
    if (req !== 1'b1 || id !== 3'd1) begin
      bad++;
      $display("FAIL basic_req got req=%b id=%0d exp 1 1",
               req, id);
    end
    rd(2'd0, d);
    total++;
    if (d !== 16'h2) begin
      bad++;
      $display("FAIL basic_pend got %0h exp 2", d);
    end
    take = 1;
    cyc();
    take = 0;
    total++;
    if (in_irq !== 1'b1 || req !== 1'b0) begin
      bad++;
      $display("FAIL basic_take got in=%b req=%b exp 1 0",
               in_irq, req);
    end
    rd(2'd0, d);
    total++;
    if (d !== 16'h0) begin
      bad++;
      $display("FAIL basic_clr got %0h exp 0", d);
    end
    rd(2'd2, d);
    total++;
    if (d !== 16'h9) begin
      bad++;
      $display("FAIL basic_active got %0h exp 9", d);
    end
    ret = 1;
    cyc();
    ret = 0;
    total++;
    if (in_irq !== 1'b0 || req !== 1'b0) begin
      bad++;
      $display("FAIL basic_ret got in=%b req=%b exp 0 0",
               in_irq, req);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
`ifdef IRQ_RR_EN
    first = 2; second = 0;
`else
    first = 0; second = 2;
`endif
    wr(2'd1, 16'hF);
    src = 4'b0101;
    cyc();
    src = 4'h0;
    cyc();
    total++;
    if (req !== 1'b1 || id !== IDW'(first)) begin
      bad++;
      $display("FAIL b2b_first got req=%b id=%0d exp 1 %0d",
               req, id, first);
    end
    take = 1; cyc(); take = 0;
    ret = 1; cyc(); ret = 0;
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got req=%b exp 0", req);
    end
    cyc();
    total++;
    if (req !== 1'b1 || id !== IDW'(second)) begin
      bad++;
      $display("FAIL b2b_second got req=%b id=%0d exp 1 %0d",
               req, id, second);
    end
    take = 1; cyc(); take = 0;
    ret = 1; cyc(); ret = 0;
    cyc();
  endtask

  task automatic test_disable();
    src = 4'b1000;
    cyc();
    src = 4'h0;
    cyc();
    total++;
    if (req !== 1'b1 || id !== 3'd3) begin
      bad++;
      $display("FAIL dis_req got req=%b id=%0d exp 1 3",
               req, id);
    end
    wr(2'd1, 16'h0);
    cyc();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL dis_drop got req=%b exp 0", req);
    end
    wr(2'd1, 16'hF);
    cyc();
    total++;
    if (req !== 1'b1 || id !== 3'd3) begin
      bad++;
      $display("FAIL dis_rearm got req=%b id=%0d exp 1 3",
               req, id);
    end
    take = 1; cyc(); take = 0;
    ret = 1; cyc(); ret = 0;
    cyc();
  endtask

  task automatic test_w1c_race();
    logic [DW-1:0] d;
    wr(2'd3, 16'h0);
    src = 4'b0100;
    sel = 1; we = 1; addr = 2'd0; wdata = 16'h4;
    cyc();
    sel = 0; we = 0; src = 4'h0;
    rd(2'd0, d);
    total++;
    if (d !== 16'h4 || req !== 1'b0) begin
      bad++;
      $display("FAIL race_set got pend=%0h req=%b exp 4 0",
               d, req);
    end
    wr(2'd0, 16'h4);
    rd(2'd0, d);
    total++;
    if (d !== 16'h0) begin
      bad++;
      $display("FAIL race_w1c got %0h exp 0", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    wr(2'd3, 16'h1);
    src = 4'b0001; cyc(); src = 4'h0; cyc();
    take = 1; cyc(); take = 0;
    src = 4'b0010; cyc(); src = 4'h0;
    total++;
    if (in_irq !== 1'b1) begin
      bad++;
      $display("FAIL mid_svc got in=%b exp 1", in_irq);
    end
    rst = 1; cyc(); rst = 0;
    total++;
    if (in_irq !== 1'b0 || req !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got in=%b req=%b exp 0 0",
               in_irq, req);
    end
    rd(2'd0, d);
    total++;
    if (d !== 16'h0) begin
      bad++;
      $display("FAIL mid_pend got %0h exp 0", d);
    end
    take = 1; ret = 1; cyc(); take = 0; ret = 0;
    cyc();
    rd(2'd2, d);
    total++;
    if (d !== 16'h0 || req !== 1'b0 || in_irq !== 1'b0) begin
      bad++;
      $display("FAIL spurious got act=%0h req=%b in=%b exp 0",
               d, req, in_irq);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      src  = src ^ NSRC'($urandom & $urandom);
      sel  = ($urandom_range(0, 3) == 0);
      we   = $urandom_range(0, 1) == 1;
      addr = 2'($urandom_range(0, 3));
      wdata = DW'($urandom);
      if (addr == 2'd3 && $urandom_range(0, 3) != 0)
        wdata[0] = 1'b1;
      take = ($urandom_range(0, 3) == 0);
      ret  = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      cyc();
      total++;
      if (req !== mreq || in_irq !== min) begin
        bad++;
        $display("FAIL rnd_ctl n=%0d got %b%b exp %b%b",
                 n, req, in_irq, mreq, min);
      end
      total++;
      if (rdata !== mrd) begin
        bad++;
        $display("FAIL rnd_rdata n=%0d got %0h exp %0h",
                 n, rdata, mrd);
      end
      if (mreq || min) begin
        total++;
        if (id !== IDW'(mid)) begin
          bad++;
          $display("FAIL rnd_id n=%0d got %0d exp %0d",
                   n, id, mid);
        end
      end
    end
    sel = 0; we = 0; take = 0; ret = 0; rst = 0;
  endtask

  initial begin
    rst = 1; src = '0; sel = 0; we = 0;
    addr = '0; wdata = '0; take = 0; ret = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_disable();
    test_w1c_race();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
